// File: rtl/display_serial_rx.sv
// Serial-to-parallel receiver for the display link: MSB-first frames into a one-entry holding register.
// Optional registered seven-segment decode of the held byte when RX_SEG_DECODE_EN is defined.
module display_serial_rx #(
    parameter int DW   = 8,
    parameter int LEAD = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_RDY_s,
    input  logic          DATA_in_s,
    input  logic          rd_ack,
    output logic [DW-1:0] DATA_out,
    output logic          out_VALID,
    output logic          state_cmp,
    output logic          frm_err,
    output logic          ovr_err
`ifdef RX_SEG_DECODE_EN
    ,
    output logic [6:0]    seg_hi,
    output logic [6:0]    seg_lo
`endif
);

    localparam int LW = (LEAD > 1) ? $clog2(LEAD) : 1;
    localparam int BW = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [LW-1:0] LEAD_INIT = LW'(LEAD - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DW - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_END   = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    state_t        state_r, state_nx;
    logic [LW-1:0] lead_cnt_r, lead_cnt_nx;
    logic [BW-1:0] bit_cnt_r, bit_cnt_nx;
    logic [DW-1:0] shreg_r, shreg_nx;
    logic [DW-1:0] data_r, data_nx;
    logic          valid_r, valid_nx;
    logic          cmp_r, cmp_nx;
    logic          frm_r, frm_nx;
    logic          ovr_r, ovr_nx;
    logic          commit_s;

    // Frame sequencing plus commit/handshake decisions for the holding register
    always_comb begin
        state_nx    = state_r;
        lead_cnt_nx = lead_cnt_r;
        bit_cnt_nx  = bit_cnt_r;
        shreg_nx    = shreg_r;
        data_nx     = data_r;
        valid_nx    = valid_r;
        cmp_nx      = 1'b0;
        frm_nx      = 1'b0;
        ovr_nx      = ovr_r;
        commit_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (in_RDY_s) begin
                    bit_cnt_nx = '0;
                    if (LEAD == 1) begin
                        state_nx = ST_SHIFT;
                    end else begin
                        state_nx    = ST_LEAD;
                        lead_cnt_nx = LEAD_INIT;
                    end
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_LEAD: begin
                if (!in_RDY_s) begin
                    frm_nx      = 1'b1;
                    lead_cnt_nx = '0;
                    state_nx    = ST_IDLE;
                end else if (lead_cnt_r == LW'(1)) begin
                    lead_cnt_nx = '0;
                    state_nx    = ST_SHIFT;
                end else begin
                    lead_cnt_nx = lead_cnt_r - LW'(1);
                end
            end
            ST_SHIFT: begin
                if (!in_RDY_s) begin
                    frm_nx     = 1'b1;
                    shreg_nx   = '0;
                    bit_cnt_nx = '0;
                    state_nx   = ST_IDLE;
                end else begin
                    shreg_nx = {shreg_r[DW-2:0], DATA_in_s};
                    if (bit_cnt_r == LAST_BIT) begin
                        bit_cnt_nx = '0;
                        state_nx   = ST_END;
                    end else begin
                        bit_cnt_nx = bit_cnt_r + BW'(1);
                    end
                end
            end
            ST_END: begin
                if (!in_RDY_s) begin
                    commit_s = 1'b1;
                    state_nx = ST_IDLE;
                end else begin
                    frm_nx   = 1'b1;
                    shreg_nx = '0;
                    state_nx = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!in_RDY_s) begin
                    state_nx = ST_IDLE;
                end else begin
                    state_nx = ST_DRAIN;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase

        // A commit wins over a plain ack; an ack in the commit cycle frees the slot for the new byte
        if (commit_s) begin
            if (!valid_r || rd_ack) begin
                data_nx  = shreg_r;
                valid_nx = 1'b1;
                cmp_nx   = 1'b1;
            end else begin
                ovr_nx = 1'b1;
            end
        end else if (rd_ack && valid_r) begin
            valid_nx = 1'b0;
        end else begin
            valid_nx = valid_r;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            lead_cnt_r <= '0;
            bit_cnt_r  <= '0;
            shreg_r    <= '0;
            data_r     <= '0;
            valid_r    <= 1'b0;
            cmp_r      <= 1'b0;
            frm_r      <= 1'b0;
            ovr_r      <= 1'b0;
        end else begin
            state_r    <= state_nx;
            lead_cnt_r <= lead_cnt_nx;
            bit_cnt_r  <= bit_cnt_nx;
            shreg_r    <= shreg_nx;
            data_r     <= data_nx;
            valid_r    <= valid_nx;
            cmp_r      <= cmp_nx;
            frm_r      <= frm_nx;
            ovr_r      <= ovr_nx;
        end
    end

    assign DATA_out  = data_r;
    assign out_VALID = valid_r;
    assign state_cmp = cmp_r;
    assign frm_err   = frm_r;
    assign ovr_err   = ovr_r;

`ifdef RX_SEG_DECODE_EN
    logic [6:0] seg_hi_r, seg_lo_r;

    // Active-high segments, bit order gfedcba
    function automatic logic [6:0] hex2seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'b0111111;
            4'h1: seg = 7'b0000110;
            4'h2: seg = 7'b1011011;
            4'h3: seg = 7'b1001111;
            4'h4: seg = 7'b1100110;
            4'h5: seg = 7'b1101101;
            4'h6: seg = 7'b1111101;
            4'h7: seg = 7'b0000111;
            4'h8: seg = 7'b1111111;
            4'h9: seg = 7'b1101111;
            4'hA: seg = 7'b1110111;
            4'hB: seg = 7'b1111100;
            4'hC: seg = 7'b0111001;
            4'hD: seg = 7'b1011110;
            4'hE: seg = 7'b1111001;
            4'hF: seg = 7'b1110001;
            default: seg = 7'b0111111;
        endcase
        return seg;
    endfunction

    // Segment patterns follow the held byte one cycle later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_hi_r <= 7'b0111111;
            seg_lo_r <= 7'b0111111;
        end else begin
            seg_hi_r <= hex2seg(data_r[7:4]);
            seg_lo_r <= hex2seg(data_r[3:0]);
        end
    end

    assign seg_hi = seg_hi_r;
    assign seg_lo = seg_lo_r;
`endif

endmodule

// File: tb/tb_display_serial_rx.sv
// Self-checking bench for display_serial_rx: directed and randomized frames against a frame-level model.
module tb_display_serial_rx;

    localparam int DW   = 8;
    localparam int LEAD = 1;
    localparam int FL   = LEAD + DW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_RDY_s;
    logic          DATA_in_s;
    logic          rd_ack;
    logic [DW-1:0] DATA_out;
    logic          out_VALID;
    logic          state_cmp;
    logic          frm_err;
    logic          ovr_err;
`ifdef RX_SEG_DECODE_EN
    logic [6:0]    seg_hi;
    logic [6:0]    seg_lo;
`endif

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ovr;

    display_serial_rx #(.DW(DW), .LEAD(LEAD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_RDY_s  (in_RDY_s),
        .DATA_in_s (DATA_in_s),
        .rd_ack    (rd_ack),
        .DATA_out  (DATA_out),
        .out_VALID (out_VALID),
        .state_cmp (state_cmp),
        .frm_err   (frm_err),
        .ovr_err   (ovr_err)
`ifdef RX_SEG_DECODE_EN
        ,
        .seg_hi    (seg_hi),
        .seg_lo    (seg_lo)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input logic ecmp, input logic efrm);
        chk("state_cmp", 32'(state_cmp), 32'(ecmp));
        chk("frm_err", 32'(frm_err), 32'(efrm));
        chk("out_VALID", 32'(out_VALID), 32'(m_valid));
        chk("DATA_out", 32'(DATA_out), 32'(m_data));
        chk("ovr_err", 32'(ovr_err), 32'(m_ovr));
    endtask

    // Frame with n high cycles; only n == LEAD+DW is well formed. Optional ack at the deciding edge.
    task automatic frame(input logic [DW-1:0] b, input int n, input logic ack);
        int   m;
        logic good, ecmp, efrm;
        good = (n == FL);
        m    = (n < FL) ? n : FL;
        for (int j = 0; j <= n + 1; j++) begin
            @(negedge clk);
            if (j > 0) begin
                ecmp = 1'b0;
                efrm = 1'b0;
                if (j == m + 1) begin
                    if (good) begin
                        if (!m_valid || ack) begin
                            m_data  = b;
                            m_valid = 1'b1;
                            ecmp    = 1'b1;
                        end else begin
                            m_ovr = 1'b1;
                        end
                    end else begin
                        efrm = 1'b1;
                        if (ack) m_valid = 1'b0;
                    end
                end
                check_all(ecmp, efrm);
            end
            in_RDY_s  = (j < n);
            DATA_in_s = (j >= LEAD && j < FL) ? b[DW-1-(j-LEAD)] : 1'($urandom);
            rd_ack    = ack && (j == m);
        end
    endtask

    task automatic ack_pulse();
        @(negedge clk);
        in_RDY_s = 1'b0;
        rd_ack   = 1'b1;
        @(negedge clk);
        rd_ack  = 1'b0;
        m_valid = 1'b0;
        check_all(1'b0, 1'b0);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            check_all(1'b0, 1'b0);
            in_RDY_s = 1'b0;
            rd_ack   = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] b;
        int            n;
        int            sel;
        logic          ack;

        rst_n     = 1'b1;
        in_RDY_s  = 1'b0;
        DATA_in_s = 1'b0;
        rd_ack    = 1'b0;
        m_data    = '0;
        m_valid   = 1'b0;
        m_ovr     = 1'b0;
        #1 rst_n = 1'b0;
        #1 check_all(1'b0, 1'b0);
`ifdef RX_SEG_DECODE_EN
        chk("seg_hi_rst", 32'(seg_hi), 32'(7'b0111111));
        chk("seg_lo_rst", 32'(seg_lo), 32'(7'b0111111));
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Nominal, short then good, long then good
        frame(8'hA5, FL, 1'b0);
        ack_pulse();
        frame(8'h3C, LEAD + 4, 1'b0);
        frame(8'h3C, FL, 1'b0);
        ack_pulse();
        frame(8'h99, FL + 3, 1'b0);
        frame(8'h5A, FL, 1'b0);
        ack_pulse();

        // Overrun and recovery, then commit coinciding with ack
        frame(8'h11, FL, 1'b0);
        frame(8'h22, FL, 1'b0);
        ack_pulse();
        frame(8'h44, FL, 1'b0);
        frame(8'h33, FL, 1'b1);
        idle(1);

        for (int i = 0; i < 25; i++) begin
            sel = int'($urandom_range(0, 3));
            b   = DW'($urandom);
            ack = 1'($urandom_range(0, 1));
            if (sel == 0) n = int'($urandom_range(1, FL - 1));
            else if (sel == 1) n = int'($urandom_range(FL + 1, FL + 4));
            else n = FL;
            frame(b, n, ack);
            if ($urandom_range(0, 2) == 0) ack_pulse();
            idle(int'($urandom_range(0, 2)));
        end

        // Reset in the middle of a frame with the holding register full
        ack_pulse();
        frame(8'h77, FL, 1'b0);
        for (int j = 0; j < LEAD + 5; j++) begin
            @(negedge clk);
            in_RDY_s  = 1'b1;
            DATA_in_s = 1'($urandom);
        end
        @(negedge clk);
        #2;
        rst_n    = 1'b0;
        in_RDY_s = 1'b0;
        rd_ack   = 1'b0;
        m_data   = '0;
        m_valid  = 1'b0;
        m_ovr    = 1'b0;
        #1 check_all(1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        frame(8'hFF, FL, 1'b0);
        ack_pulse();

        frame(8'h7E, FL, 1'b0);
`ifdef RX_SEG_DECODE_EN
        @(negedge clk);
        chk("seg_hi_7E", 32'(seg_hi), 32'(7'b0000111));
        chk("seg_lo_7E", 32'(seg_lo), 32'(7'b1111001));
`endif
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/display_serial_rx.md
# display_serial_rx

Serial-to-parallel receiver for the display link. It sits at the far end of the one-bit display channel and reassembles each MSB-first frame into a parallel byte. The byte goes into a single-entry holding register with a valid/ack handshake to the downstream consumer, and the block flags framing and overrun errors.

## Interface
Parameters:
- `DW`, default 8: data bits per frame.
- `LEAD`, default 1: cycles of `in_RDY_s` high before the first data bit. Must be ≥1.

Ports:
- `clk` in 1: the single clock. All logic is on the rising edge.
- `rst_n` in 1: reset. Asynchronous, active-low.
- `in_RDY_s` in 1: frame-active strobe from the transmitter.
- `DATA_in_s` in 1: serial data bit, MSB first.
- `rd_ack` in 1: consumer accepts `DATA_out`. Only meaningful while `out_VALID` = 1.
- `DATA_out` out DW: received byte in the holding register.
- `out_VALID` out 1: holding register is full.
- `state_cmp` out 1: one-cycle pulse on each successful frame commit.
- `frm_err` out 1: one-cycle pulse on a framing error.
- `ovr_err` out 1: sticky overrun flag. Cleared only by reset.
- `seg_hi` out 7: seven-segment pattern for the upper nibble. Present only with `RX_SEG_DECODE_EN`.
- `seg_lo` out 7: seven-segment pattern for the lower nibble. Present only with `RX_SEG_DECODE_EN`.

## Operation
**Frame format**, as sampled at rising edges:
- `in_RDY_s` is high for `LEAD`+`DW` consecutive cycles, then low for at least one cycle.
- No data is carried during the first `LEAD` cycles.
- The following `DW` cycles carry bits `DW-1` down to `0` on `DATA_in_s`.

**State machine** (states `IDLE`, `LEAD`, `SHIFT`, `END`, `DRAIN`):
- `IDLE`: when `in_RDY_s` is sampled 1, that edge counts as lead cycle 1.
  - If `LEAD` = 1, go to `SHIFT`.
  - Otherwise go to `LEAD` with counter = `LEAD`-1.
- `LEAD`: each edge with `in_RDY_s` = 1 decrements the counter. At 0, go to `SHIFT`.
  - `in_RDY_s` = 0: pulse `frm_err` and go to `IDLE`.
- `SHIFT`: each edge does `shreg <= {shreg[DW-2:0], DATA_in_s}` and increments the bit counter. After `DW` bits, go to `END`.
  - `in_RDY_s` = 0 during any bit: pulse `frm_err`, discard the partial byte, go to `IDLE`.
- `END`: `in_RDY_s` must be sampled 0.
  - If 0: commit and go to `IDLE`.
  - If 1: pulse `frm_err`, discard the byte, go to `DRAIN`.
- `DRAIN`: wait for `in_RDY_s` = 0, then go to `IDLE`. A fresh frame is only recognized after a low cycle.

**Commit:**
- Holding register empty, or `rd_ack` = 1 in the same cycle:
  - `DATA_out <= shreg`.
  - `out_VALID <= 1`.
  - `state_cmp` pulses.
- Holding register full and no `rd_ack`:
  - The new byte is dropped and `DATA_out` is unchanged.
  - `ovr_err <= 1`.
  - `state_cmp` does not pulse.

**Handshake:**
- `rd_ack` with `out_VALID` = 1 and no commit clears `out_VALID` on the next edge.
- `rd_ack` with `out_VALID` = 0 is ignored.

**Reset** (any state, mid-frame included): `DATA_out` = 0, `out_VALID` = 0, `state_cmp` = 0, `frm_err` = 0, `ovr_err` = 0, shift register = 0, counters = 0, FSM = `IDLE`.

## Timing
- All outputs are registered.
- With the `in_RDY_s` rising edge first sampled at edge T:
  - Data bits are sampled at T+`LEAD` … T+`LEAD`+`DW`-1.
  - The `END` check is at T+`LEAD`+`DW`.
  - `DATA_out`, `out_VALID` and `state_cmp` are visible after that edge.
  - Defaults: commit at T+9, visible in cycle T+9..T+10.
- `state_cmp` and `frm_err` are high for exactly one cycle.
- Back-to-back frames need at least one low cycle between them. The `END` low cycle satisfies this, so the minimum period is `LEAD`+`DW`+1 cycles.
- `rd_ack` to `out_VALID` low: 1 cycle.

## Configuration
- `RX_SEG_DECODE_EN` defined:
  - `seg_hi` and `seg_lo` are registered hex-to-seven-segment decodes of `DATA_out[7:4]` and `DATA_out[3:0]`, active-high, bit order gfedcba.
  - They update one cycle after `DATA_out` changes.
  - Reset value is the pattern for "0", 7'b0111111.
  - Requires `DW` = 8.
- `RX_SEG_DECODE_EN` not defined: the ports and their logic are absent. All other behaviour is identical.

## Test plan
- **Nominal frame:** `in_RDY_s` high 9 cycles, bits 1,0,1,0,0,1,0,1, then low → `DATA_out` = 8'hA5, `out_VALID` = 1 and a 1-cycle `state_cmp` at T+9; `frm_err` stays 0.
- **Short frame:** `in_RDY_s` drops after 4 data bits → `frm_err` pulses, `out_VALID` stays 0. The next valid frame carrying 8'h3C is received correctly.
- **Long frame:** `in_RDY_s` held high 12 cycles → `frm_err` pulse at `END`, no commit. The block re-arms only after `in_RDY_s` goes low.
- **Overrun and recovery:**
  - Frame 8'h11 is received with no ack, then frame 8'h22 arrives → `DATA_out` stays 8'h11 and `ovr_err` = 1 (sticky).
  - Then `rd_ack` → `out_VALID` = 0 next cycle.
  - Simultaneous commit of 8'h33 with `rd_ack` → `DATA_out` = 8'h33, `out_VALID` stays 1, no new overrun.
- **Reset mid-frame:** assert `rst_n` = 0 during bit 5 → all outputs are 0 immediately. After release, frame 8'hFF is received correctly.
- **With `RX_SEG_DECODE_EN`:** frame 8'h7E → `seg_hi` = 7'b0000111, `seg_lo` = 7'b1111001, one cycle after `DATA_out` updates.
